// File: rtl/ibex_pkg_pext.sv
// Shared types for the P/M-extension multiplier sequencer: mode encoding, FSM states
// and the meaning of each bit of the decoded cycle-count field.
package ibex_pkg_pext;

    typedef enum logic [1:0] {
        M8x8   = 2'd0,
        M16x16 = 2'd1,
        M32x16 = 2'd2,
        M32x32 = 2'd3
    } mult_pext_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_HI = 2'd1,
        ACCUM  = 2'd2
    } mult_seq_state_e;

    localparam int MULT_CYC_EXTRA_BIT = 0;
    localparam int MULT_CYC_ACCUM_BIT = 1;

endpackage

// File: rtl/ibex_mult_pext_seq.sv
// Cycle sequencer for the shared P/M multiplier: phase selects, intermediate writes, adder request.
// Optional multi-cycle-op counter enabled by defining IBEX_PEXT_MULT_PERF_EN.
module ibex_mult_pext_seq
    import ibex_pkg_pext::*;
#(
    parameter int PerfCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mult_en_i,
    input  logic                    kill_i,
    input  logic [1:0]              cycle_count_i,
    input  logic [1:0]              mult_mode_i,
    input  logic                    alu_gnt_i,
    output logic                    mult_phase_o,
    output logic                    imd_we_o,
    output logic                    alu_req_o,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic [1:0]              mode_q_o,
    output logic [PerfCntWidth-1:0] perf_cnt_o
);

    mult_seq_state_e state_q, state_d;
    mult_pext_mode_e mode_q;
    logic            accum_q;
    logic            latch_en;

    // Only the accumulate bit survives past IDLE; the extra-phase bit is consumed when choosing the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= M32x32;
            accum_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                mode_q  <= mult_pext_mode_e'(mult_mode_i);
                accum_q <= cycle_count_i[MULT_CYC_ACCUM_BIT];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        mult_phase_o = 1'b0;
        imd_we_o     = 1'b0;
        alu_req_o    = 1'b0;
        valid_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mult_en_i) begin
                    if (cycle_count_i == 2'b00) begin
                        valid_o = 1'b1;
                    end else begin
                        imd_we_o = 1'b1;
                        latch_en = 1'b1;
                        state_d  = cycle_count_i[MULT_CYC_EXTRA_BIT] ? MUL_HI : ACCUM;
                    end
                end
            end
            MUL_HI: begin
                mult_phase_o = 1'b1;
                if (accum_q) begin
                    imd_we_o = 1'b1;
                    state_d  = ACCUM;
                end else begin
                    valid_o = 1'b1;
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                alu_req_o = 1'b1;
                if (alu_gnt_i) begin
                    valid_o = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush or reset wins over any grant and must not leave a half-written intermediate.
        if (kill_i || rst_i) begin
            state_d   = IDLE;
            latch_en  = 1'b0;
            imd_we_o  = 1'b0;
            alu_req_o = 1'b0;
            valid_o   = 1'b0;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign mode_q_o = mode_q;

`ifdef IBEX_PEXT_MULT_PERF_EN
    logic                    perf_inc;
    logic [PerfCntWidth-1:0] perf_cnt_q;

    assign perf_inc = valid_o && (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cnt_q <= '0;
        end else if (perf_inc) begin
            perf_cnt_q <= perf_cnt_q + PerfCntWidth'(1);
        end
    end

    assign perf_cnt_o = perf_cnt_q;
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Bench for ibex_mult_pext_seq: hand-written cycle tables for the corner cases, then random
// traffic checked against an op-level model that tracks the remaining phases of the current op.
module tb_ibex_mult_pext_seq;
    import ibex_pkg_pext::*;

    localparam int PCW = 2;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           mult_en_i = 1'b0;
    logic           kill_i = 1'b0;
    logic [1:0]     cycle_count_i = 2'b00;
    logic [1:0]     mult_mode_i = 2'b00;
    logic           alu_gnt_i = 1'b0;
    logic           mult_phase_o, imd_we_o, alu_req_o, valid_o, busy_o;
    logic [1:0]     mode_q_o;
    logic [PCW-1:0] perf_cnt_o;

    int checks = 0;
    int errors = 0;

    ibex_mult_pext_seq #(.PerfCntWidth(PCW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mult_en_i    (mult_en_i),
        .kill_i       (kill_i),
        .cycle_count_i(cycle_count_i),
        .mult_mode_i  (mult_mode_i),
        .alu_gnt_i    (alu_gnt_i),
        .mult_phase_o (mult_phase_o),
        .imd_we_o     (imd_we_o),
        .alu_req_o    (alu_req_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .mode_q_o     (mode_q_o),
        .perf_cnt_o   (perf_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, kill, rst;
        logic [1:0] cc, mode;
        logic       gnt;
        logic       v, i, r, p, b;
        logic       mchk;
        logic [1:0] mexp;
        int         perf;
    } vec_t;

    typedef enum {TK_HI_DONE, TK_HI_IMD, TK_ACC} token_e;

    vec_t       tbl[$];
    token_e     pend[$];
    logic [1:0] mdl_mode;
    int         mdl_perf;

    function automatic int perfExp(input int raw);
`ifdef IBEX_PEXT_MULT_PERF_EN
        return raw % (1 << PCW);
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic en, kill, rst, input logic [1:0] cc, mode,
                                   input logic gnt, v, i, r, p, b, mchk,
                                   input logic [1:0] mexp, input int perf);
        vec_t t;
        t.en = en; t.kill = kill; t.rst = rst; t.cc = cc; t.mode = mode; t.gnt = gnt;
        t.v = v; t.i = i; t.r = r; t.p = p; t.b = b; t.mchk = mchk; t.mexp = mexp; t.perf = perf;
        tbl.push_back(t);
    endfunction

    // Called at posedge+1; checks mid-cycle, then advances the model across the next edge.
    task automatic applyStimulus(input vec_t t, input bit useTbl, input string tag);
        logic ev, ei, er, ep, eb;
        logic [1:0] em;
        int ef;
        mult_en_i = t.en; kill_i = t.kill; rst_i = t.rst;
        cycle_count_i = t.cc; mult_mode_i = t.mode; alu_gnt_i = t.gnt;

        ev = 0; ei = 0; er = 0; ep = 0;
        eb = (pend.size() != 0);
        if (pend.size() == 0) begin
            if (t.en) begin
                if (t.cc == 2'b00) ev = 1;
                else ei = 1;
            end
        end else begin
            case (pend[0])
                TK_HI_DONE: begin ep = 1; ev = 1; end
                TK_HI_IMD:  begin ep = 1; ei = 1; end
                default:    begin er = 1; ev = t.gnt; end
            endcase
        end
        if (t.kill || t.rst) begin ev = 0; ei = 0; er = 0; end
        em = mdl_mode;
        ef = perfExp(mdl_perf);

        #4;
        if (useTbl) begin
            checkOutput({tag, ".valid"}, valid_o, t.v);
            checkOutput({tag, ".imd_we"}, imd_we_o, t.i);
            checkOutput({tag, ".alu_req"}, alu_req_o, t.r);
            checkOutput({tag, ".phase"}, mult_phase_o, t.p);
            checkOutput({tag, ".busy"}, busy_o, t.b);
            checkOutput({tag, ".perf"}, int'(perf_cnt_o), perfExp(t.perf));
            if (t.b || t.mchk) checkOutput({tag, ".mode_q"}, int'(mode_q_o), int'(t.mexp));
        end else begin
            checkOutput({tag, ".valid"}, valid_o, ev);
            checkOutput({tag, ".imd_we"}, imd_we_o, ei);
            checkOutput({tag, ".alu_req"}, alu_req_o, er);
            checkOutput({tag, ".phase"}, mult_phase_o, ep);
            checkOutput({tag, ".busy"}, busy_o, eb);
            checkOutput({tag, ".perf"}, int'(perf_cnt_o), ef);
            if (eb) checkOutput({tag, ".mode_q"}, int'(mode_q_o), int'(em));
        end

        @(posedge clk);
        if (t.rst) begin
            pend.delete();
            mdl_mode = M32x32;
            mdl_perf = 0;
        end else if (t.kill) begin
            pend.delete();
        end else if (pend.size() == 0) begin
            if (t.en && t.cc != 2'b00) begin
                mdl_mode = t.mode;
                if (t.cc[0]) pend.push_back(t.cc[1] ? TK_HI_IMD : TK_HI_DONE);
                if (t.cc[1]) pend.push_back(TK_ACC);
            end
        end else if (pend[0] != TK_ACC || t.gnt) begin
            if (ev) mdl_perf++;
            void'(pend.pop_front());
        end
        #1;
    endtask

    initial begin
        vec_t rv;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        mdl_mode = M32x32;
        mdl_perf = 0;
        #1;
        checkOutput("reset.mode_q", int'(mode_q_o), int'(M32x32));
        checkOutput("reset.busy", busy_o, 0);
        checkOutput("reset.valid", valid_o, 0);
        checkOutput("reset.perf", int'(perf_cnt_o), 0);
        #3;
        @(posedge clk);
        #1;

        //      en kil rst cc     mode    gnt v  i  r  p  b  mchk mexp   perf
        // single-cycle op
        addVec(1, 0, 0, 2'b00, M16x16, 0, 1, 0, 0, 0, 0, 0, M32x32, 0);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 0, M32x32, 0);
        // two-phase op without accumulate
        addVec(1, 0, 0, 2'b01, M8x8,   0, 0, 1, 0, 0, 0, 0, M32x32, 0);
        addVec(1, 0, 0, 2'b01, M8x8,   0, 1, 0, 0, 1, 1, 0, M8x8,   0);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 0, M8x8,   1);
        // full op with three grant stalls; mid-op input changes ignored
        addVec(1, 0, 0, 2'b11, M32x32, 0, 0, 1, 0, 0, 0, 0, M32x32, 1);
        addVec(1, 0, 0, 2'b00, M8x8,   0, 0, 1, 0, 1, 1, 0, M32x32, 1);
        addVec(1, 0, 0, 2'b00, M8x8,   0, 0, 0, 1, 0, 1, 0, M32x32, 1);
        addVec(1, 0, 0, 2'b01, M8x8,   0, 0, 0, 1, 0, 1, 0, M32x32, 1);
        addVec(1, 0, 0, 2'b10, M16x16, 0, 0, 0, 1, 0, 1, 0, M32x32, 1);
        addVec(1, 0, 0, 2'b11, M16x16, 1, 1, 0, 1, 0, 1, 0, M32x32, 1);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 0, M32x32, 2);
        // single multiply plus accumulate, granted immediately
        addVec(1, 0, 0, 2'b10, M32x16, 1, 0, 1, 0, 0, 0, 0, M32x32, 2);
        addVec(1, 0, 0, 2'b10, M32x16, 1, 1, 0, 1, 0, 1, 0, M32x16, 2);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 0, M32x16, 3);
        // kill beats a same-cycle grant
        addVec(1, 0, 0, 2'b10, M16x16, 0, 0, 1, 0, 0, 0, 0, M32x16, 3);
        addVec(1, 1, 0, 2'b10, M16x16, 1, 0, 0, 0, 0, 1, 0, M16x16, 3);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 0, M16x16, 3);
        // reset during the high phase
        addVec(1, 0, 0, 2'b11, M8x8,   0, 0, 1, 0, 0, 0, 0, M16x16, 3);
        addVec(1, 0, 1, 2'b11, M8x8,   0, 0, 0, 0, 1, 1, 0, M8x8,   3);
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 1, M32x32, 0);
        // four back-to-back multi-cycle ops wrap the 2-bit counter
        for (int k = 0; k < 4; k++) begin
            addVec(1, 0, 0, 2'b01, M16x16, 0, 0, 1, 0, 0, 0, 0, M32x32, k);
            addVec(1, 0, 0, 2'b01, M16x16, 0, 1, 0, 0, 1, 1, 0, M16x16, k);
        end
        addVec(0, 0, 0, 2'b00, M8x8,   0, 0, 0, 0, 0, 0, 1, M16x16, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            applyStimulus(tbl[n], 1'b1, $sformatf("row%0d", n));
        end

        for (int n = 0; n < 400; n++) begin
            rv.en   = ($urandom_range(0, 3) != 0);
            rv.kill = ($urandom_range(0, 15) == 0);
            rv.rst  = ($urandom_range(0, 63) == 0);
            rv.cc   = 2'($urandom_range(0, 3));
            rv.mode = 2'($urandom_range(0, 3));
            rv.gnt  = ($urandom_range(0, 2) != 0);
            rv.v = 0; rv.i = 0; rv.r = 0; rv.p = 0; rv.b = 0;
            rv.mchk = 0; rv.mexp = 2'b00; rv.perf = 0;
            applyStimulus(rv, 1'b0, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
